// File: rtl/ins_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : ins_fetch_if
//  Brief    : Bus bundle between the instruction-fetch stage and its
//             environment (control FSM on one side, instruction ROM on the
//             other). The fetch stage connects through the master modport.
//  Revision : 1.0  initial release
// ============================================================================
interface ins_fetch_if #(
    parameter int PC_W = 8
);
    // Commands from the control FSM
    logic            en_fetch_pulse;
    logic            en_pc_pulse;
    logic [1:0]      pc_ctrl;
    // Instruction ROM port
    logic [15:0]     rom_data;
    logic [PC_W-1:0] rom_addr;
    logic            rom_rd_en;
    // Status and decoded instruction fields
    logic            en1;
    logic [3:0]      opcode;
    logic [1:0]      rd;
    logic [1:0]      rs;
    logic [7:0]      imm;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            fetch_overrun;

    modport master (
        input  en_fetch_pulse, en_pc_pulse, pc_ctrl, rom_data,
        output rom_addr, rom_rd_en, en1, opcode, rd, rs, imm, pc, busy,
               fetch_overrun
    );

    modport slave (
        output en_fetch_pulse, en_pc_pulse, pc_ctrl, rom_data,
        input  rom_addr, rom_rd_en, en1, opcode, rd, rs, imm, pc, busy,
               fetch_overrun
    );
endinterface
`default_nettype wire

// File: rtl/ins_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : ins_fetch
//  Brief    : Instruction-fetch stage. Owns the program counter, issues one
//             ROM read per fetch request, latches the 16-bit instruction and
//             exposes its opcode/rd/rs/imm fields plus a fetch-done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module ins_fetch #(
    parameter int PC_W    = 8,
    parameter int ROM_LAT = 1      // ROM read latency in edges, 1..4
) (
    input  logic      clk,
    input  logic      rst,
    ins_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] c_rom_lat = 3'(ROM_LAT);

    state_t          r_state,     w_state_next;
    logic [2:0]      r_cnt,       w_cnt_next;
    logic [PC_W-1:0] r_rom_addr,  w_rom_addr_next;
    logic            r_rom_rd_en, w_rom_rd_en_next;
    logic            r_en1,       w_en1_next;
    logic            r_busy,      w_busy_next;
    logic            r_overrun,   w_overrun_next;
    logic [15:0]     r_ir,        w_ir_next;
    logic [PC_W-1:0] r_pc,        w_pc_next;

    // Register every piece of state; reset aborts any fetch in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_rom_addr  <= '0;
            r_rom_rd_en <= 1'b0;
            r_en1       <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_ir        <= 16'h0000;
            r_pc        <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_rom_addr  <= w_rom_addr_next;
            r_rom_rd_en <= w_rom_rd_en_next;
            r_en1       <= w_en1_next;
            r_busy      <= w_busy_next;
            r_overrun   <= w_overrun_next;
            r_ir        <= w_ir_next;
            r_pc        <= w_pc_next;
        end
    end

    // Fetch sequencing; strobes are computed one state early so they leave
    // the block straight from flops
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_rom_addr_next  = r_rom_addr;
        w_rom_rd_en_next = 1'b0;
        w_en1_next       = 1'b0;
        w_busy_next      = r_busy;
        w_ir_next        = r_ir;
        // Any request outside IDLE (including DONE) is dropped but remembered
        w_overrun_next   = r_overrun | (bus.en_fetch_pulse & (r_state != S_IDLE));

        case (r_state)
            S_IDLE: begin
                if (bus.en_fetch_pulse) begin
                    // Address is the PC before any same-cycle PC update
                    w_rom_addr_next  = r_pc;
                    w_rom_rd_en_next = 1'b1;
                    w_busy_next      = 1'b1;
                    w_state_next     = S_REQ;
                end
            end
            S_REQ: begin
                w_cnt_next   = c_rom_lat;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 3'd1) begin
                    w_ir_next    = bus.rom_data;
                    w_en1_next   = 1'b1;
                    w_busy_next  = 1'b0;
                    w_cnt_next   = 3'd0;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // PC update runs independently of the fetch sequencer; jumps use the
    // instruction latched before this edge
    always_comb begin
        w_pc_next = r_pc;
        if (bus.en_pc_pulse) begin
            case (bus.pc_ctrl)
                2'b01:   w_pc_next = r_pc + PC_W'(1);
                2'b10:   w_pc_next = PC_W'(r_ir[7:0]);
                default: w_pc_next = r_pc;
            endcase
        end
    end

    assign bus.rom_addr      = r_rom_addr;
    assign bus.rom_rd_en     = r_rom_rd_en;
    assign bus.en1           = r_en1;
    assign bus.busy          = r_busy;
    assign bus.fetch_overrun = r_overrun;
    assign bus.pc            = r_pc;
    assign bus.opcode        = r_ir[15:12];
    assign bus.rd            = r_ir[11:10];
    assign bus.rs            = r_ir[9:8];
    assign bus.imm           = r_ir[7:0];

endmodule
`default_nettype wire

// File: doc/ins_fetch.md
# ins_fetch

Instruction-fetch stage directly upstream of the control FSM. It owns the program counter and issues read requests to the instruction ROM. It latches the returned 16-bit instruction and splits it into the opcode, rd, rs and immediate fields the control FSM decodes. It raises `en1` (fetch done) so the FSM can leave IF, and it applies the FSM's `en_pc_pulse`/`pc_ctrl` PC-update commands.

## Interface
- `PC_W`, 8: program-counter and ROM address width.
- `ROM_LAT`, 1: ROM read latency in clock edges, legal range 1..4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `en_fetch_pulse`  in  1  one-cycle request to fetch the instruction at the current PC.
- `en_pc_pulse`  in  1  one-cycle PC-update strobe.
- `pc_ctrl`  in  2  PC update select: 01 = PC+1, 10 = load `imm`, 00/11 = hold.
- `rom_data`  in  16  ROM read data, valid ROM_LAT edges after the edge that sampled `rom_rd_en`.
- `rom_addr`  out  PC_W  ROM read address.
- `rom_rd_en`  out  1  ROM read strobe, high exactly one cycle per fetch.
- `en1`  out  1  fetch-done pulse, one cycle.
- `opcode`  out  4  `ir[15:12]`.
- `rd`  out  2  `ir[11:10]`.
- `rs`  out  2  `ir[9:8]`.
- `imm`  out  8  `ir[7:0]`.
- `pc`  out  PC_W  current program counter.
- `busy`  out  1  high in REQ and WAIT.
- `fetch_overrun`  out  1  sticky flag, set when `en_fetch_pulse` arrives while `busy`.

## Operation
- Reset values (asynchronous, while `rst`=1):
  - `pc`=0, `ir`=0, so `opcode`/`rd`/`rs`/`imm` are all 0.
  - `rom_addr`=0, `rom_rd_en`=0, `en1`=0, `busy`=0, `fetch_overrun`=0.
  - State = IDLE, latency counter = 0.
- Fetch FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on `en_fetch_pulse`, capture `rom_addr` <= `pc` and go to REQ. Otherwise stay.
  - REQ: `rom_rd_en`=1 for this single cycle; load counter with ROM_LAT; go to WAIT.
  - WAIT: decrement the counter each edge. At the edge where the counter reaches 1: `ir` <= `rom_data`, `en1` <= 1, go to DONE.
  - DONE: `en1`=1 for this cycle only; go to IDLE unconditionally.
- Fetch request while `busy`: the request is ignored, `fetch_overrun` <= 1, and the fetch in progress is unaffected. `fetch_overrun` clears only on `rst`.
- `en_fetch_pulse` in DONE is also ignored and also sets `fetch_overrun`.
- PC update is independent of the FSM state and is evaluated every edge when `en_pc_pulse`=1:
  - 01: `pc` <= `pc`+1, modulo 2^PC_W (0xFF -> 0x00 at PC_W=8).
  - 10: `pc` <= `imm[PC_W-1:0]`, zero-extended if PC_W>8. This is an absolute jump target taken from the currently latched instruction.
  - 00/11: `pc` holds.
- `en_fetch_pulse` and `en_pc_pulse` in the same cycle (the normal IF case): `rom_addr` captures the old `pc`, and `pc` then updates. The fetched instruction is therefore the one at the pre-increment address.
- `ir` and its field outputs are stable from the DONE cycle until the next fetch completes.
- `rst` asserted mid-fetch aborts immediately to IDLE with all reset values. A ROM response arriving after reset is not latched.

## Timing
- Let E0 be the edge that samples `en_fetch_pulse`=1.
  - `rom_rd_en` is high in the cycle after E0.
  - The ROM samples `rom_addr` at E1.
  - `ir` is latched at E(1+ROM_LAT).
  - `en1` is high in the cycle after E(1+ROM_LAT).
- Fetch latency from E0 to `en1` rising is ROM_LAT+1 edges.
- Minimum spacing between accepted fetches is ROM_LAT+3 edges.
- `en1`, `busy` and `rom_rd_en` are registered outputs with no combinational path from any input.
- A PC update is visible on `pc` in the cycle after the edge that sampled `en_pc_pulse`.

## Test plan
- Reset then sequential fetch, ROM_LAT=1, ROM[0]=0x2A05, ROM[1]=0x3600:
  - Drive IF-style pulses (`en_fetch_pulse`=1 and `en_pc_pulse`=1 with `pc_ctrl`=01 in the same cycle).
  - Required: `rom_addr`=0, then `en1` 2 edges later with `opcode`=2, `rd`=2, `rs`=2, `imm`=0x05, and `pc`=1.
  - The next fetch returns 0x3600 from address 1.
- Jump: latch an instruction with `imm`=0x40, then pulse `en_pc_pulse` with `pc_ctrl`=10.
  - Required: `pc`=0x40 next cycle, and the following fetch reads address 0x40.
- Wrap and hold:
  - `pc`=0xFF, pulse `pc_ctrl`=01 -> `pc`=0x00.
  - Pulse with `pc_ctrl`=00 or 11 -> `pc` unchanged.
- Overrun: ROM_LAT=3, issue a second `en_fetch_pulse` during WAIT.
  - Required: exactly one `rom_rd_en`, one `en1` at latency 4, and `fetch_overrun`=1 staying high until `rst`.
- Reset mid-fetch: assert `rst` during WAIT and release it.
  - Required: all outputs 0 and state IDLE, no `en1`, and the late ROM data is not latched.
  - A subsequent fetch proceeds normally from `pc`=0.
